// File: rtl/ram_pkg.sv
// Shared definitions for the slab RAM port master: class field,
// class-to-burst mapping, base addresses, op encoding and FSM states.
package ram_pkg;

    // Class field sits in the top two bits of a 16-bit beat address.
    localparam int CLASS_HI = 15;
    localparam int CLASS_LO = 14;

    localparam logic [15:0] CLASS0_BASE = 16'h0000;
    localparam logic [15:0] CLASS1_BASE = 16'h4000;
    localparam logic [15:0] CLASS2_BASE = 16'h8000;
    localparam logic [15:0] CLASS3_BASE = 16'hC000;

    // Largest burst; also the free space demanded before accepting a command.
    localparam int MAX_BEATS = 8;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD_REQ,
        S_RD_WAIT
    } state_e;

    // class0 = 1 beat (64B) ... class3 = 8 beats (512B)
    function automatic logic [3:0] class_beats(input logic [1:0] cls);
        return 4'd1 << cls;
    endfunction

endpackage

// File: rtl/ram_rd_fifo.sv
// First-word-fall-through FIFO holding returned read beats (data + last).
// Ports: push/push_data in, pop in, head/empty/count out.
module ram_rd_fifo #(
    parameter int W     = 513,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_push  = push && (cnt_q != CW'(DEPTH));
        do_pop   = pop && (cnt_q != '0);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem[rd_ptr_q];
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/ram_port_master.sv
// Initiator for one slab RAM port: command + write stream in, RAM port
// transactions out, returned read beats buffered into a read stream.
// Ports: cmd_*, wdata_*, rdata_* (user side); m_* (RAM side);
// done pulse per completed command; err_unexpected sticky stray-beat flag.
module ram_port_master
    import ram_pkg::*;
#(
    parameter int DATA_W        = 512,
    parameter int ADDR_W        = 16,
    parameter int RD_FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              wdata_valid,
    input  logic [DATA_W-1:0] wdata,
    output logic              wdata_ready,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_last,
    input  logic              rdata_ready,
    output logic              done,
    output logic              err_unexpected,
    output logic              m_rx_valid,
    output logic [DATA_W-1:0] m_rx_data,
    input  logic              m_rx_ready,
    input  logic              m_tx_valid,
    input  logic [DATA_W-1:0] m_tx_data,
    output logic              m_tx_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_read_or_write
);

    localparam int CW = $clog2(RD_FIFO_DEPTH) + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        beats_q, beats_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              live_q;

    logic              push;
    logic              push_last;
    logic              pop;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_head;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     free_slots;
    logic              credit_ok;
    logic              last_beat;

    assign pop        = !fifo_empty && rdata_ready;
    // Credit uses occupancy after this cycle's pop.
    assign free_slots = CW'(RD_FIFO_DEPTH) - (fifo_count - CW'(pop));
    assign credit_ok  = (free_slots >= CW'(MAX_BEATS));
    assign last_beat  = ((cnt_q + 4'd1) == beats_q);

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        beats_d         = beats_q;
        cnt_d           = cnt_q;
        done_d          = 1'b0;
        err_d           = err_q | (m_tx_valid && (state_q != S_RD_WAIT));
        cmd_ready       = 1'b0;
        wdata_ready     = 1'b0;
        m_rx_valid      = 1'b0;
        m_rx_data       = '0;
        m_read_or_write = 1'b0;
        push            = 1'b0;
        push_last       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // Not ready in the done cycle nor in the first cycle out of reset.
                cmd_ready = live_q && !done_q && credit_ok;
                if (cmd_valid && cmd_ready) begin
                    addr_d  = cmd_addr;
                    beats_d = class_beats(cmd_addr[ADDR_W-1 -: 2]);
                    cnt_d   = '0;
                    state_d = (cmd_op == OP_WRITE) ? S_WR : S_RD_REQ;
                end
            end
            S_WR: begin
                m_rx_valid      = wdata_valid;
                m_rx_data       = wdata;
                wdata_ready     = m_rx_ready;
                m_read_or_write = 1'b1;
                if (wdata_valid && m_rx_ready) begin
                    cnt_d = cnt_q + 4'd1;
                    if (last_beat) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_RD_REQ: begin
                m_rx_valid = 1'b1;
                if (m_rx_ready) begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (m_tx_valid) begin
                    push      = 1'b1;
                    push_last = last_beat;
                    cnt_d     = cnt_q + 4'd1;
                    if (last_beat) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            beats_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beats_q <= beats_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            live_q  <= 1'b1;
        end
    end

    ram_rd_fifo #(
        .W    (DATA_W + 1),
        .DEPTH(RD_FIFO_DEPTH)
    ) u_rd_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data({push_last, m_tx_data}),
        .pop      (pop),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign rdata_valid    = !fifo_empty;
    assign rdata          = fifo_head[DATA_W-1:0];
    assign rdata_last     = !fifo_empty && fifo_head[DATA_W];
    assign done           = done_q;
    assign err_unexpected = err_q;
    assign m_tx_ready     = 1'b1;
    assign m_addr         = addr_q;

endmodule

// File: tb/tb_ram_port_master.sv
// Directed bench for ram_port_master: writes, reads, credit stall,
// mid-burst reset and stray RAM beats, against a small RAM model.
module tb_ram_port_master;
    import ram_pkg::*;

    localparam int DW = 512;
    localparam int AW = 16;

    typedef logic [DW:0] beat_t;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [AW-1:0] cmd_addr;
    logic          wdata_valid;
    logic [DW-1:0] wdata;
    logic          wdata_ready;
    logic          rdata_valid;
    logic [DW-1:0] rdata;
    logic          rdata_last;
    logic          rdata_ready;
    logic          done;
    logic          err_unexpected;
    logic          m_rx_valid;
    logic [DW-1:0] m_rx_data;
    logic          m_rx_ready;
    logic          m_tx_valid;
    logic [DW-1:0] m_tx_data;
    logic          m_tx_ready;
    logic [AW-1:0] m_addr;
    logic          m_read_or_write;

    ram_port_master #(
        .DATA_W       (DW),
        .ADDR_W       (AW),
        .RD_FIFO_DEPTH(16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_addr       (cmd_addr),
        .wdata_valid    (wdata_valid),
        .wdata          (wdata),
        .wdata_ready    (wdata_ready),
        .rdata_valid    (rdata_valid),
        .rdata          (rdata),
        .rdata_last     (rdata_last),
        .rdata_ready    (rdata_ready),
        .done           (done),
        .err_unexpected (err_unexpected),
        .m_rx_valid     (m_rx_valid),
        .m_rx_data      (m_rx_data),
        .m_rx_ready     (m_rx_ready),
        .m_tx_valid     (m_tx_valid),
        .m_tx_data      (m_tx_data),
        .m_tx_ready     (m_tx_ready),
        .m_addr         (m_addr),
        .m_read_or_write(m_read_or_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    int mon_hs = 0;

    logic [DW-1:0] ram_m [logic [15:0]];
    beat_t         exp_q [$];

    always @(posedge clk) begin
        if (rst_n && m_rx_valid && m_rx_ready) mon_hs++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int nbeats(input logic [15:0] a);
        case (a[15:14])
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 8;
        endcase
    endfunction

    function automatic logic [DW-1:0] wpat(input logic [15:0] a);
        return {16{16'hA5A5, a}};
    endfunction

    function automatic logic [DW-1:0] rd_data(input logic [15:0] a);
        if (ram_m.exists(a)) return ram_m[a];
        return {16{~a, a}};
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic op, input logic [15:0] a);
        int g = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        while (!cmd_ready && g < 40) begin
            step();
            g++;
        end
        check("cmd_ready_wait", (g < 40), 1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] a, input bit gap);
        int n   = nbeats(a);
        int k   = 0;
        int g   = 0;
        int hs0 = mon_hs;
        bit addr_ok = 1'b1;
        bit data_ok = 1'b1;
        issue(OP_WRITE, a);
        while (k < n && g < 64) begin
            wdata_valid = !(gap && (g % 2 == 1));
            wdata       = wpat(a + 16'(k));
            #1;
            if (m_addr !== a || m_read_or_write !== 1'b1) addr_ok = 1'b0;
            if (m_rx_valid && m_rx_ready) begin
                if (m_rx_data !== wdata || !wdata_ready) data_ok = 1'b0;
                ram_m[a + 16'(k)] = m_rx_data;
                k++;
            end
            step();
            g++;
        end
        wdata_valid = 1'b0;
        wdata       = '0;
        check("wr_done", done, 1);
        check("wr_busy_on_done", cmd_ready, 0);
        check("wr_addr_rw", addr_ok, 1);
        check("wr_data", data_ok, 1);
        step();
        check("wr_hs_count", 32'(mon_hs - hs0), 32'(n));
        check("wr_done_pulse", done, 0);
        check("wr_ready_after", cmd_ready, 1);
    endtask

    task automatic rd_req(input logic [15:0] a);
        int req = 0;
        int g   = 0;
        check("rdreq_valid", m_rx_valid, 1);
        check("rdreq_rw", m_read_or_write, 0);
        check("rdreq_addr", m_addr, a);
        while (m_rx_valid && g < 10) begin
            if (m_rx_ready) req++;
            step();
            g++;
        end
        check("rdreq_hs", 32'(req), 1);
    endtask

    task automatic rd_beats(input logic [15:0] a, input int n);
        logic [DW-1:0] d;
        for (int k = 0; k < n; k++) begin
            d          = rd_data(a + 16'(k));
            m_tx_valid = 1'b1;
            m_tx_data  = d;
            exp_q.push_back({(k == n - 1), d});
            step();
        end
        m_tx_valid = 1'b0;
        m_tx_data  = '0;
        check("rd_done", done, 1);
    endtask

    task automatic drain(input int n);
        beat_t e;
        rdata_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            #1;
            check("rd_valid", rdata_valid, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rd_data", rdata, e[DW-1:0]);
                check("rd_last", rdata_last, e[DW]);
            end
            step();
        end
        rdata_ready = 1'b0;
        #1;
    endtask

    initial begin
        beat_t e;
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = 1'b0;
        cmd_addr    = '0;
        wdata_valid = 1'b0;
        wdata       = '0;
        rdata_ready = 1'b0;
        m_rx_ready  = 1'b1;
        m_tx_valid  = 1'b0;
        m_tx_data   = '0;
        step();
        step();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_wdata_ready", wdata_ready, 0);
        check("rst_m_rx_valid", m_rx_valid, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_rw", m_read_or_write, 0);
        check("rst_done", done, 0);
        check("rst_err", err_unexpected, 0);
        check("rst_rdata_valid", rdata_valid, 0);
        check("rst_rdata_last", rdata_last, 0);
        check("rst_m_tx_ready", m_tx_ready, 1);
        rst_n = 1'b1;
        step();
        check("ready_after_rst", cmd_ready, 1);

        // class0 write, then class3 write with gaps
        do_write(16'h0010, 1'b0);
        do_write(16'hC000, 1'b1);
        check("m_addr_held_c3", m_addr, 16'hC000);

        // class2 read, consumer stalled, then drained
        issue(OP_READ, 16'h8000);
        rd_req(16'h8000);
        rd_beats(16'h8000, 4);
        step();
        check("c2_buffered", rdata_valid, 1);
        check("c2_head_not_last", rdata_last, 0);
        drain(4);
        check("c2_empty", rdata_valid, 0);

        // credit stall: 9 buffered beats with a read pending
        issue(OP_READ, 16'hC000);
        rd_req(16'hC000);
        rd_beats(16'hC000, 8);
        issue(OP_READ, 16'h0020);
        rd_req(16'h0020);
        rd_beats(16'h0020, 1);
        step();
        cmd_valid = 1'b1;
        cmd_op    = OP_READ;
        cmd_addr  = 16'h0030;
        for (int i = 0; i < 3; i++) begin
            check("credit_stall", cmd_ready, 0);
            check("credit_no_req", m_rx_valid, 0);
            step();
        end
        rdata_ready = 1'b1;
        #1;
        check("credit_release", cmd_ready, 1);
        e = exp_q.pop_front();
        check("credit_pop_data", rdata, e[DW-1:0]);
        step();
        rdata_ready = 1'b0;
        cmd_valid   = 1'b0;
        rd_req(16'h0030);
        rd_beats(16'h0030, 1);
        drain(9);
        check("credit_empty", rdata_valid, 0);

        // write then read back class1
        do_write(16'h4000, 1'b0);
        check("rb_model0", ram_m[16'h4000], wpat(16'h4000));
        check("rb_model1", ram_m[16'h4001], wpat(16'h4001));
        issue(OP_READ, 16'h4000);
        rd_req(16'h4000);
        rd_beats(16'h4000, 2);
        drain(2);

        // reset in RD_WAIT after 2 of 8 beats
        issue(OP_READ, 16'hC000);
        rd_req(16'hC000);
        for (int k = 0; k < 2; k++) begin
            m_tx_valid = 1'b1;
            m_tx_data  = rd_data(16'hC000 + 16'(k));
            step();
        end
        m_tx_valid = 1'b0;
        check("mid_rdata_valid", rdata_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cmd_ready", cmd_ready, 0);
        check("mid_rst_rdata_valid", rdata_valid, 0);
        check("mid_rst_rdata_last", rdata_last, 0);
        check("mid_rst_m_rx_valid", m_rx_valid, 0);
        check("mid_rst_m_addr", m_addr, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err_unexpected, 0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_ready", cmd_ready, 1);
        check("post_rst_empty", rdata_valid, 0);

        // stray RAM beat while idle
        m_tx_valid = 1'b1;
        m_tx_data  = {16{32'hDEADBEEF}};
        step();
        m_tx_valid = 1'b0;
        check("stray_err", err_unexpected, 1);
        check("stray_dropped", rdata_valid, 0);
        repeat (3) step();
        check("stray_err_held", err_unexpected, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
